// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter: state encoding and
// default sizing for operands and the watchdog counter.
package booth_pkg;

    localparam int DEF_WIDTH   = 3;
    localparam int DEF_TIMEOUT = 31;

    function automatic int cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int DEF_TO_W = cnt_w(DEF_TIMEOUT);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] ARM   = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = IDLE,
        S_START = START,
        S_ARM   = ARM,
        S_WAIT  = WAIT,
        S_ACK   = ACK
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first asserted request at or after the
// pointer, wrapping around the request vector.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  gid_o,
    output logic            any_o
);

    // Scan from farthest to nearest so the nearest asserted request wins.
    always_comb begin
        gid_o = '0;
        any_o = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % NREQ]) begin
                gid_o = IDW'((int'(ptr_i) + k) % NREQ);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier among NREQ requesters
// using a 4-phase req/done handshake, with a watchdog on the multiplier.
module booth_mul_arbiter
    import booth_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*WIDTH-1:0] op_a,
    input  logic [NREQ*WIDTH-1:0] op_b,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy,
    output logic [WIDTH-1:0]     mul_multiplicador,
    output logic [WIDTH-1:0]     mul_multiplicando,
    output logic                 mul_start,
    input  logic                 mul_fin,
    input  logic [2*WIDTH-1:0]   mul_resultado
);

    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TO_W = cnt_w(TIMEOUT);

    state_e             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               err_q, err_d;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic [IDW-1:0]     pick_gid;
    logic               pick_any;
    logic               wd_expired;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gid_o (pick_gid),
        .any_o (pick_any)
    );

    // Expiry on the TIMEOUT-th cycle spent in ARM+WAIT.
    assign wd_expired = (wd_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gid_d   = pick_gid;
                    a_d     = op_a[int'(pick_gid)*WIDTH +: WIDTH];
                    b_d     = op_b[int'(pick_gid)*WIDTH +: WIDTH];
                    state_d = S_START;
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                wd_d = wd_q + TO_W'(1);
                if (wd_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else if (!mul_fin) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                wd_d = wd_q + TO_W'(1);
                if (mul_fin) begin
                    res_d   = mul_resultado;
                    err_d   = 1'b0;
                    state_d = S_ACK;
                end else if (wd_expired) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!req[gid_q]) begin
                    err_d   = 1'b0;
                    ptr_d   = (int'(gid_q) == NREQ - 1) ? '0 : gid_q + IDW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign done              = (state_q == S_ACK) ? (NREQ'(1) << gid_q) : '0;
    assign err               = err_q;
    assign res               = res_q;
    assign busy              = (state_q != S_IDLE);
    assign mul_start         = (state_q == S_START);
    assign mul_multiplicador = a_q;
    assign mul_multiplicando = b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: behavioural multiplier with selectable fin
// behaviour, plus scenario tasks checked against arithmetic expectations.
module tb_booth_mul_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 3;
    localparam int LAT  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [5:0]    op_a, op_b;
    logic [1:0]    done;
    logic          err;
    logic [5:0]    res;
    logic          busy;
    logic [2:0]    mul_multiplicador, mul_multiplicando;
    logic          mul_start;
    logic          mul_fin = 1'b0;
    logic [5:0]    mul_resultado = 6'd0;

    int checks = 0;
    int errors = 0;

    // Multiplier model: 0 = normal, 1 = fin stuck low, 2 = fin left high after start
    int         mdl_mode = 0;
    int         mdl_cnt = 0;
    int         starts = 0;
    logic [5:0] mdl_prod = 6'd0;

    always #5 clk = ~clk;

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(31)) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .op_a              (op_a),
        .op_b              (op_b),
        .done              (done),
        .err               (err),
        .res               (res),
        .busy              (busy),
        .mul_multiplicador (mul_multiplicador),
        .mul_multiplicando (mul_multiplicando),
        .mul_start         (mul_start),
        .mul_fin           (mul_fin),
        .mul_resultado     (mul_resultado)
    );

    function automatic logic [5:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
        int ia, ib;
        ia = $signed(a);
        ib = $signed(b);
        return 6'(ia * ib);
    endfunction

    function automatic int rr_expect(input logic [1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (mul_start) begin
            starts   <= starts + 1;
            mdl_prod <= ref_mul(mul_multiplicador, mul_multiplicando);
            mdl_cnt  <= 1;
            if (mdl_mode != 2) mul_fin <= 1'b0;
        end else if (mdl_cnt != 0) begin
            if (mdl_mode == 2 && mdl_cnt == 2) mul_fin <= 1'b0;
            if (mdl_cnt == LAT) begin
                mdl_cnt <= 0;
                if (mdl_mode != 1) begin
                    mul_fin       <= 1'b1;
                    mul_resultado <= mdl_prod;
                end
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
    end

    task automatic do_reset();
        rst  = 1'b1;
        req  = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [2:0] a, input logic [2:0] b);
        op_a[id*W +: W] = a;
        op_b[id*W +: W] = b;
        req[id] = 1'b1;
    endtask

    task automatic release_req(input int id);
        req[id] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int id, input int limit, output int cyc);
        cyc = 0;
        while (done[id] !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_any(input int limit, output int cyc);
        cyc = 0;
        while (done === 2'b00 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        op_a = '0;
        op_b = '0;
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 2'b00) begin errors++; $display("FAIL reset_done got %b want 00", done); end
        checks++; if (err !== 1'b0 || res !== 6'd0) begin errors++; $display("FAIL reset_err_res got err=%b res=%b want 0/000000", err, res); end
        checks++; if (mul_start !== 1'b0 || mul_multiplicador !== 3'd0 || mul_multiplicando !== 3'd0) begin
            errors++; $display("FAIL reset_mul got start=%b a=%b b=%b want 0/000/000", mul_start, mul_multiplicador, mul_multiplicando);
        end
    endtask

    task automatic test_single();
        int cyc;
        int s0;
        s0 = starts;
        issue(0, 3'b011, 3'b110);
        wait_done(0, 40, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL single_latency got %0d want 7", cyc); end
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL single_done got %b want 01", done); end
        checks++; if (res !== 6'b111010) begin errors++; $display("FAIL single_res got %b want 111010", res); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", err); end
        checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL single_start_pulses got %0d want 1", starts - s0); end
        release_req(0);
        checks++; if (busy !== 1'b0 || done !== 2'b00) begin errors++; $display("FAIL single_exit got busy=%b done=%b want 0/00", busy, done); end
        checks++; if (res !== 6'b111010) begin errors++; $display("FAIL single_res_hold got %b want 111010", res); end
    endtask

    task automatic test_both();
        int cyc;
        do_reset();
        issue(0, 3'b011, 3'b011);
        issue(1, 3'b100, 3'b100);
        wait_any(40, cyc);
        checks++; if (done !== 2'b01) begin errors++; $display("FAIL both_first got %b want 01", done); end
        checks++; if (res !== 6'b001001) begin errors++; $display("FAIL both_res0 got %b want 001001", res); end
        release_req(0);
        wait_any(40, cyc);
        checks++; if (done !== 2'b10) begin errors++; $display("FAIL both_second got %b want 10", done); end
        checks++; if (res !== 6'b010000) begin errors++; $display("FAIL both_res1 got %b want 010000", res); end
        release_req(1);
    endtask

    task automatic test_alternate();
        int cyc, w, wobs, last, ptr;
        logic [1:0] pend;
        logic [2:0] a [2];
        logic [2:0] b [2];
        last = -1;
        ptr  = 0;
        pend = 2'b11;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = 3'($urandom);
            b[i] = 3'($urandom);
            issue(i, a[i], b[i]);
        end
        for (int n = 0; n < 6; n++) begin
            wait_any(60, cyc);
            checks++; if (cyc >= 60) begin errors++; $display("FAIL alt_timeout got %0d want <60", cyc); end
            w    = rr_expect(pend, ptr);
            wobs = (done == 2'b01) ? 0 : (done == 2'b10) ? 1 : -1;
            checks++; if (done !== 2'(1 << w)) begin errors++; $display("FAIL alt_grant got %b want %b", done, 2'(1 << w)); end
            checks++; if (res !== ref_mul(a[w], b[w])) begin errors++; $display("FAIL alt_res got %b want %b", res, ref_mul(a[w], b[w])); end
            checks++; if (wobs == last) begin errors++; $display("FAIL alt_consecutive got %0d want not %0d", wobs, last); end
            last = wobs;
            release_req(w);
            ptr  = (w + 1) % NREQ;
            a[w] = 3'($urandom);
            b[w] = 3'($urandom);
            issue(w, a[w], b[w]);
        end
    endtask

    task automatic test_operand_hold();
        int cyc;
        logic [2:0] a, b;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            a = 3'($urandom);
            b = 3'($urandom);
            issue(0, a, b);
            @(negedge clk);
            @(negedge clk);
            op_a = 6'($urandom);
            op_b = 6'($urandom);
            wait_done(0, 40, cyc);
            checks++; if (res !== ref_mul(a, b)) begin errors++; $display("FAIL hold_res got %b want %b", res, ref_mul(a, b)); end
            checks++; if (mul_multiplicador !== a || mul_multiplicando !== b) begin
                errors++; $display("FAIL hold_operands got %b/%b want %b/%b", mul_multiplicador, mul_multiplicando, a, b);
            end
            release_req(0);
        end
    endtask

    task automatic test_early_drop();
        int cyc;
        logic [2:0] a, b;
        a = 3'($urandom);
        b = 3'($urandom);
        issue(0, a, b);
        @(negedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        wait_done(0, 40, cyc);
        checks++; if (cyc !== 5) begin errors++; $display("FAIL early_latency got %0d want 5", cyc); end
        checks++; if (res !== ref_mul(a, b)) begin errors++; $display("FAIL early_res got %b want %b", res, ref_mul(a, b)); end
        @(negedge clk);
        checks++; if (done !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL early_exit got done=%b busy=%b want 00/0", done, busy); end
    endtask

    task automatic test_timeout();
        int cyc;
        mdl_mode = 1;
        issue(0, 3'($urandom), 3'($urandom));
        wait_done(0, 80, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL to_latency got %0d want 33", cyc); end
        checks++; if (done !== 2'b01 || err !== 1'b1) begin errors++; $display("FAIL to_flags got done=%b err=%b want 01/1", done, err); end
        checks++; if (res !== 6'd0) begin errors++; $display("FAIL to_res got %b want 000000", res); end
        release_req(0);
        checks++; if (done !== 2'b00 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL to_exit got done=%b err=%b busy=%b want 00/0/0", done, err, busy);
        end
        mdl_mode = 0;
    endtask

    task automatic test_stale();
        int cyc;
        mdl_mode = 0;
        issue(0, 3'b011, 3'b011);
        wait_done(0, 40, cyc);
        release_req(0);
        mdl_mode = 2;
        issue(0, 3'b010, 3'b111);
        wait_done(0, 40, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL stale_latency got %0d want 7", cyc); end
        checks++; if (res !== 6'b111110 || err !== 1'b0) begin errors++; $display("FAIL stale_res got %b err=%b want 111110/0", res, err); end
        release_req(0);
        mdl_mode = 0;
    endtask

    task automatic test_reset_wait();
        int cyc;
        logic [2:0] a, b;
        issue(0, 3'b011, 3'b101);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 2'b00 || mul_start !== 1'b0) begin
            errors++; $display("FAIL rstw_state got busy=%b done=%b start=%b want 0/00/0", busy, done, mul_start);
        end
        checks++; if (res !== 6'd0 || err !== 1'b0) begin errors++; $display("FAIL rstw_res got %b err=%b want 000000/0", res, err); end
        rst    = 1'b0;
        req[0] = 1'b0;
        @(negedge clk);
        a = 3'($urandom);
        b = 3'($urandom);
        issue(0, a, b);
        wait_done(0, 40, cyc);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL rstw_latency got %0d want 7", cyc); end
        checks++; if (res !== ref_mul(a, b) || err !== 1'b0) begin errors++; $display("FAIL rstw_res_after got %b err=%b want %b/0", res, err, ref_mul(a, b)); end
        release_req(0);
    endtask

    task automatic test_random();
        int cyc, w, ptr;
        logic [1:0] pend;
        logic [2:0] a [2];
        logic [2:0] b [2];
        do_reset();
        ptr = 0;
        for (int n = 0; n < 8; n++) begin
            pend = 2'($urandom_range(1, 3));
            for (int i = 0; i < NREQ; i++) begin
                if (pend[i]) begin
                    a[i] = 3'($urandom);
                    b[i] = 3'($urandom);
                    issue(i, a[i], b[i]);
                end
            end
            while (pend != 2'b00) begin
                wait_any(60, cyc);
                w = rr_expect(pend, ptr);
                checks++; if (done !== 2'(1 << w)) begin errors++; $display("FAIL rand_grant got %b want %b", done, 2'(1 << w)); end
                checks++; if (res !== ref_mul(a[w], b[w]) || err !== 1'b0) begin
                    errors++; $display("FAIL rand_res got %b err=%b want %b/0", res, err, ref_mul(a[w], b[w]));
                end
                release_req(w);
                pend[w] = 1'b0;
                ptr = (w + 1) % NREQ;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst  = 1'b1;
        req  = 2'b00;
        op_a = '0;
        op_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_both();
        test_alternate();
        test_operand_hold();
        test_early_drop();
        test_timeout();
        test_stale();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Shares one Booth multiplier (multiplicador, multiplicando, start, fin, resultado) between NREQ requesters. Each requester uses a 4-phase req/done handshake. The block grants requesters round-robin, latches the operands, pulses start, and waits for fin. It then returns the 2*WIDTH-bit product to the granted requester. A watchdog aborts the operation if the multiplier never finishes.

Parameters:
NREQ, 2, number of requesters (2..8).
WIDTH, 3, operand width; product is 2*WIDTH.
TIMEOUT, 31, maximum cycles spent in ARM+WAIT before abort.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
req  input  NREQ  per-requester request level.
op_a  input  NREQ*WIDTH  multiplier operand, slice i belongs to requester i.
op_b  input  NREQ*WIDTH  multiplicand operand, slice i.
done  output  NREQ  per-requester completion level (one-hot or zero).
err  output  1  valid while any done bit is high; 1 = watchdog abort.
res  output  2*WIDTH  product, valid while any done bit is high.
busy  output  1  high in every state except IDLE.
mul_multiplicador  output  WIDTH  to multiplier.
mul_multiplicando  output  WIDTH  to multiplier.
mul_start  output  1  one-cycle start pulse.
mul_fin  input  1  from multiplier.
mul_resultado  input  2*WIDTH  from multiplier.

Behaviour:
- Reset, synchronous to clk, rst high:
  - state=IDLE, rr pointer=0, done=0, err=0, res=0, busy=0, mul_start=0, operand registers=0.
  - Reset mid-operation abandons the operation. No done is issued.
- IDLE:
  - Pick the first asserted req starting at the pointer, wrapping.
  - Latch gid, op_a[gid], op_b[gid] into registers; go to START.
  - No req: stay in IDLE.
- START: mul_start=1 for exactly this cycle; go to ARM; clear watchdog counter.
- ARM: wait for mul_fin==0, which clears the stale fin from a previous run or a reset. On fin==0, go to WAIT.
- WAIT: on mul_fin==1, latch mul_resultado into res, err=0, go to ACK.
- Watchdog:
  - Counts every cycle in ARM and WAIT.
  - When it reaches TIMEOUT, set res=0, err=1, go to ACK.
  - This covers fin stuck high and fin never rising.
- ACK:
  - done[gid]=1; res and err stay stable.
  - When req[gid]==0 is sampled: done=0, err=0, pointer=(gid+1) mod NREQ, go to IDLE. res keeps its last value.
- mul_multiplicador and mul_multiplicando are driven from the latched registers in every state. They do not change between grant and ACK exit.
- Requester operands are sampled only at grant. Changing op_a/op_b afterwards has no effect.
- Dropping req[gid] before ACK is ignored. The operation completes and done is raised. The requester is then already low, so ACK exits on the next cycle (done high for 1 cycle).
- Simultaneous requests: the pointer gives priority. No requester waits more than NREQ-1 services.
- Latency: req sampled in IDLE at edge k → mul_start high in cycle k+1 → done high the cycle after fin is sampled high. Minimum request-to-done latency is multiplier latency + 3 cycles.
- Arithmetic: the block does no arithmetic. res is mul_resultado verbatim (two's-complement, 2*WIDTH).

Decomposition:
- Shared package booth_pkg holds:
  - state encoding localparams: IDLE, START, ARM, WAIT, ACK.
  - default WIDTH=3.
  - TIMEOUT counter width, $clog2(TIMEOUT+1).
- One sub-module, rr_picker: combinational round-robin select.
  - Inputs: req vector, pointer.
  - Outputs: gid, any.

Test Plan:
- Single request, with a bench multiplier model of 4-cycle latency: req[0], op_a=3'b011, op_b=3'b110 → one mul_start pulse; done[0] rises 7 cycles after req; res=6'b111010 (-6); err=0.
- Both requesters assert in the same cycle after reset: requester 0 (3*3) is served first, res=6'b001001. Then requester 1 (-4*-4) is served, res=6'b010000. Pointer returns to 0.
- Requester 0 re-requests continuously while requester 1 is pending → grants alternate 0,1,0,1. Never two consecutive grants to 0.
- Model holds fin stuck low → after 31 cycles, done[0]=1, err=1, res=0. Dropping req returns to IDLE.
- Model leaves fin high from the previous op and clears it 2 cycles after start → the controller stays in ARM and does not take the stale result. Correct product: 2*-1 = 6'b111110.
- rst asserted during WAIT → next cycle busy=0, done=0, mul_start=0. A new request afterwards completes normally.
